// File: rtl/audio_dac_out.sv
// Multi-channel audio DAC output stage.
// Strobed signed samples are attenuated, converted to offset binary and held
// in a per-channel pending register. At each PWM period boundary the pending
// value moves to the active register, which drives either a PWM comparator or
// a first-order sigma-delta accumulator producing the 1-bit DAC stream.
module audio_dac_out #(
  parameter int WIDTH    = 16,
  parameter int OUT_BITS = 9,
  parameter int CHANNELS = 2,
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_strb,
  input  logic [CH_BITS-1:0]             i_ch,
  input  logic signed [WIDTH-1:0]        i_sample,
  input  logic [3:0]                     i_vol,
  input  logic                           i_mode,
  input  logic                           i_ovr_clr,
  output logic [CHANNELS*OUT_BITS-1:0]   o_dac,
  output logic [CHANNELS-1:0]            o_bit,
  output logic [CHANNELS-1:0]            o_ovr
);

  localparam logic [OUT_BITS-1:0] MID = {1'b1, {(OUT_BITS-1){1'b0}}};

  // Attenuation: arithmetic right shift keeps the sign of the sample.
  function automatic logic signed [WIDTH-1:0] attenuate(
    input logic signed [WIDTH-1:0] smp,
    input logic [3:0]              sh
  );
    return smp >>> sh;
  endfunction

  logic [OUT_BITS-1:0]        cnt;
  logic                       boundary;
  logic                       mode;
  logic [OUT_BITS-1:0]        pend [CHANNELS];
  logic [OUT_BITS-1:0]        act  [CHANNELS];
  logic [OUT_BITS:0]          acc  [CHANNELS];
  logic [CHANNELS-1:0]        vld;
  logic [CHANNELS-1:0]        pwm_bit;
  logic [CHANNELS-1:0]        ovr;
  logic [CHANNELS-1:0]        cap_sel;
  logic signed [WIDTH-1:0]    shifted;
  logic [OUT_BITS-1:0]        cap_v;
  logic                       unused_bits;

  assign boundary    = &cnt;
  assign unused_bits = ^shifted;

  // Capture path: attenuate, take the top bits, flip MSB to offset binary.
  // Out-of-range channel indices simply match no channel.
  always_comb begin
    shifted = attenuate(i_sample, i_vol);
    cap_v   = {~shifted[WIDTH-1], shifted[WIDTH-2 -: OUT_BITS-1]};
    cap_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cap_sel[k] = i_strb && (i_ch == CH_BITS'(k));
    end
  end

  // Free-running period counter and mode register (mode latched at boundary).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      mode <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (boundary) mode <= i_mode;
    end
  end

  // Double buffer, overrun flags and both modulators, per channel.
  // A strobe on the boundary cycle is not an overrun: the old pending value
  // moves to active on the same edge and the new one becomes pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      ovr     <= '0;
      pwm_bit <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        pend[k] <= MID;
        act[k]  <= MID;
        acc[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (boundary && vld[k]) act[k] <= pend[k];

        if (cap_sel[k]) begin
          pend[k] <= cap_v;
          vld[k]  <= 1'b1;
        end else if (boundary) begin
          vld[k]  <= 1'b0;
        end

        if (cap_sel[k] && vld[k] && !boundary) ovr[k] <= 1'b1;
        else if (i_ovr_clr)                    ovr[k] <= 1'b0;

        pwm_bit[k] <= (cnt < act[k]);

        if (boundary && (i_mode != mode)) acc[k] <= '0;
        else acc[k] <= {1'b0, acc[k][OUT_BITS-1:0]} + {1'b0, act[k]};
      end
    end
  end

  // Output mapping: active words, and the modulator selected by the latched mode.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      o_dac[k*OUT_BITS +: OUT_BITS] = act[k];
      o_bit[k] = mode ? acc[k][OUT_BITS] : pwm_bit[k];
    end
    o_ovr = ovr;
  end

endmodule
